// File: rtl/izh_pkg.sv
// Izhikevich neuron shared types and Q10 constants.
// Used by the state-update top and its dw datapath.
package izh_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    INTEGRATE,
    COMMIT
  } state_t;

  localparam int A      = 20;
  localparam int B      = 205;
  localparam int C      = -66560;
  localparam int D      = 8192;
  localparam int V_TH   = 30720;
  localparam int V_INIT = -66560;

endpackage

// File: rtl/izhikevich_state_update_calc_dw.sv
// Combinational recovery-variable derivative:
// out = A*(B*v - w)*step, fixed-point Qn.
module calc_dw
  import izh_pkg::*;
#(
  parameter int N = 20,
  parameter int Q = 10,
  parameter int A = izh_pkg::A,
  parameter int B = izh_pkg::B
) (
  input  logic signed [N-1:0] v,
  input  logic signed [N-1:0] w,
  input  logic signed [N-1:0] step,
  output logic signed [N-1:0] out
);

  localparam logic signed [N-1:0] AC = N'(A);
  localparam logic signed [N-1:0] BC = N'(B);

  function automatic logic signed [N-1:0] mul(
    input logic signed [N-1:0] x,
    input logic signed [N-1:0] y
  );
    logic signed [2*N-1:0] p;
    p   = x * y;
    mul = N'(p >>> Q);
  endfunction

  function automatic logic signed [N-1:0] sat(
    input logic signed [N:0] x
  );
    if (x[N] != x[N-1])
      sat = x[N] ? {1'b1, {(N-1){1'b0}}}
                 : {1'b0, {(N-1){1'b1}}};
    else
      sat = x[N-1:0];
  endfunction

  logic signed [N-1:0] bv;
  logic signed [N-1:0] diff;
  logic signed [N-1:0] t;

  // B*v, subtract w with clamp, then scale by A and step
  always_comb begin
    bv   = mul(BC, v);
    diff = sat({bv[N-1], bv} - {w[N-1], w});
    t    = mul(AC, diff);
    out  = mul(t, step);
  end

endmodule

// File: rtl/izhikevich_state_update.sv
// Izhikevich neuron v/w integrator: four-cycle
// capture/integrate/commit step with spike reset.
module izhikevich_state_update
  import izh_pkg::*;
#(
  parameter int N      = 20,
  parameter int Q      = 10,
  parameter int A      = izh_pkg::A,
  parameter int B      = izh_pkg::B,
  parameter int C      = izh_pkg::C,
  parameter int D      = izh_pkg::D,
  parameter int V_TH   = izh_pkg::V_TH,
  parameter int V_INIT = izh_pkg::V_INIT,
  parameter int W_INIT = -13326
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] i_in,
  input  logic signed [N-1:0] step_in,
  input  logic signed [N-1:0] dv_in,
  output logic signed [N-1:0] i_q,
  output logic signed [N-1:0] step_q,
  output logic signed [N-1:0] v_out,
  output logic signed [N-1:0] w_out,
  output logic                busy,
  output logic                done,
  output logic                spike
);

  localparam logic signed [N-1:0] CC  = N'(C);
  localparam logic signed [N-1:0] DC  = N'(D);
  localparam logic signed [N-1:0] VTC = N'(V_TH);
  localparam logic signed [N-1:0] VIC = N'(V_INIT);
  localparam logic signed [N-1:0] WIC = N'(W_INIT);

  function automatic logic signed [N-1:0] sat(
    input logic signed [N:0] x
  );
    if (x[N] != x[N-1])
      sat = x[N] ? {1'b1, {(N-1){1'b0}}}
                 : {1'b0, {(N-1){1'b1}}};
    else
      sat = x[N-1:0];
  endfunction

  state_t state_q;
  state_t state_d;

  logic signed [N-1:0] dv_q;
  logic signed [N-1:0] dw_q;
  logic signed [N-1:0] v_tmp;
  logic signed [N-1:0] w_tmp;
  logic signed [N-1:0] dw;

  calc_dw #(
    .N(N),
    .Q(Q),
    .A(A),
    .B(B)
  ) u_calc_dw (
    .v   (v_out),
    .w   (w_out),
    .step(step_q),
    .out (dw)
  );

  assign busy = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: one state per cycle, start only honoured in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = CAPTURE;
      CAPTURE:   state_d = INTEGRATE;
      INTEGRATE: state_d = COMMIT;
      COMMIT:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath registers and registered done/spike pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q    <= '0;
      step_q <= '0;
      v_out  <= VIC;
      w_out  <= WIC;
      dv_q   <= '0;
      dw_q   <= '0;
      v_tmp  <= '0;
      w_tmp  <= '0;
      done   <= 1'b0;
      spike  <= 1'b0;
    end else begin
      done  <= 1'b0;
      spike <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            i_q    <= i_in;
            step_q <= step_in;
          end
        end
        CAPTURE: begin
          dv_q <= dv_in;
          dw_q <= dw;
        end
        INTEGRATE: begin
          v_tmp <= sat({v_out[N-1], v_out}
                     + {dv_q[N-1], dv_q});
          w_tmp <= sat({w_out[N-1], w_out}
                     + {dw_q[N-1], dw_q});
        end
        COMMIT: begin
          done <= 1'b1;
          if (v_tmp >= VTC) begin
            v_out <= CC;
            w_out <= sat({w_tmp[N-1], w_tmp}
                       + {DC[N-1], DC});
            spike <= 1'b1;
          end else begin
            v_out <= v_tmp;
            w_out <= w_tmp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_izhikevich_state_update.sv
// Directed self-checking bench for the
// Izhikevich state-update block.
module tb_izhikevich_state_update;

  localparam int N = 20;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic signed [N-1:0] i_in;
  logic signed [N-1:0] step_in;
  logic signed [N-1:0] dv_in;
  logic signed [N-1:0] i_q;
  logic signed [N-1:0] step_q;
  logic signed [N-1:0] v_out;
  logic signed [N-1:0] w_out;
  logic                busy;
  logic                done;
  logic                spike;

  int checks;
  int failures;

  izhikevich_state_update dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .i_in   (i_in),
    .step_in(step_in),
    .dv_in  (dv_in),
    .i_q    (i_q),
    .step_q (step_q),
    .v_out  (v_out),
    .w_out  (w_out),
    .busy   (busy),
    .done   (done),
    .spike  (spike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    int         dv;
    int         st;
    int         cur;
    int         exp_v;
    int         exp_w;
    bit         exp_spk;
  } vec_t;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Launch one step at a negedge; returns the negedge
  // count at which done was seen (0 = never) and the
  // number of negedges busy was high before it.
  task automatic run_step(input int dv,
                          input int st,
                          input int cur,
                          output int lat,
                          output int bcnt,
                          output bit spk);
    lat  = 0;
    bcnt = 0;
    spk  = 1'b0;
    dv_in   = N'(dv);
    step_in = N'(st);
    i_in    = N'(cur);
    start   = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        spk = spike;
        break;
      end
      if (spike) spk = 1'b1;
    end
  endtask

  vec_t vt[7];
  int   lat;
  int   bc;
  bit   spk;
  int   dcnt;
  int   first;
  int   second;

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    i_in     = '0;
    step_in  = '0;
    dv_in    = '0;
    rst_n    = 1'b1;

    vt[0] = '{1, 2048,    1024, 5,
              -64512,  -13326, 0};
    vt[1] = '{0, 0,       1024, 7,
              -64512,  -13318, 0};
    vt[2] = '{1, 102400,  1024, -3,
              -66560,  -5134,  1};
    vt[3] = '{1, 97280,   1024, 100,
              -66560,  -5134,  1};
    vt[4] = '{1, 97279,   1024, 0,
              30719,   -13326, 0};
    vt[5] = '{1, -512000, 1024, 1,
              -524288, -13326, 0};
    vt[6] = '{0, 0,       1024, 2,
              -524288, -15116, 0};

    do_reset();
    chk("rst_v",    v_out, -66560);
    chk("rst_w",    w_out, -13326);
    chk("rst_busy", busy,  0);
    chk("rst_done", done,  0);
    chk("rst_spk",  spike, 0);
    chk("rst_iq",   i_q,   0);
    chk("rst_stq",  step_q, 0);

    foreach (vt[k]) begin
      if (vt[k].do_rst) do_reset();
      run_step(vt[k].dv, vt[k].st, vt[k].cur,
               lat, bc, spk);
      chk($sformatf("v%0d_lat", k),  lat, 4);
      chk($sformatf("v%0d_busy", k), bc,  3);
      chk($sformatf("v%0d_v", k),    v_out, vt[k].exp_v);
      chk($sformatf("v%0d_w", k),    w_out, vt[k].exp_w);
      chk($sformatf("v%0d_spk", k),  spk, vt[k].exp_spk);
      chk($sformatf("v%0d_iq", k),   i_q, vt[k].cur);
      chk($sformatf("v%0d_stq", k),  step_q, vt[k].st);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", k),
          {done, spike}, 0);
    end

    // start held through CAPTURE/INTEGRATE/COMMIT
    do_reset();
    dv_in   = 20'sd2048;
    step_in = 20'sd1024;
    i_in    = '0;
    start   = 1'b1;
    dcnt    = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 4) start = 1'b0;
      if (done) dcnt++;
    end
    start = 1'b0;
    chk("ign_dones", dcnt, 1);
    chk("ign_v",     v_out, -64512);
    chk("ign_busy",  busy, 0);

    // back-to-back: start held during the done cycle
    do_reset();
    dv_in   = 20'sd2048;
    step_in = 20'sd1024;
    start   = 1'b1;
    first   = 0;
    second  = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (done) begin
        if (first == 0) first = n;
        else if (second == 0) second = n;
      end
      if (first != 0 && n > first) start = 1'b0;
      else if (first == 0 && n >= 1) start = 1'b0;
      if (first == n) start = 1'b1;
    end
    start = 1'b0;
    chk("b2b_first", first, 4);
    chk("b2b_gap",   second - first, 4);
    chk("b2b_v",     v_out, -62464);
    chk("b2b_w",     w_out, -13318);

    // reset asserted while in INTEGRATE
    do_reset();
    dv_in   = 20'sd2048;
    step_in = 20'sd1024;
    i_in    = 20'sd9;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abt_busy_int", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abt_busy", busy, 0);
    chk("abt_v",    v_out, -66560);
    chk("abt_w",    w_out, -13326);
    chk("abt_iq",   i_q, 0);
    dcnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done || spike) dcnt++;
    end
    chk("abt_nodone", dcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
